// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous DEPTH-entry FIFO buffering load results for the write port.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  T                 mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port: ALU/load arbitration plus RAW pending-write scoreboard.
// Optional WB_FWD_EN adds combinational write-through forwarding ports.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_stall,
  output logic [31:0]       busy,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData
);

  wb_req_t             push_req;
  wb_req_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  wb_src_e             src;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  // Register-0 beats still handshake so the producer is not blocked.
  assign mem_ready = !fifo_full;
  assign push      = mem_valid && mem_ready && (mem_rd != '0);
  assign push_req  = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_req),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid && (alu_rd != '0)) begin
      src      = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (!fifo_empty) begin
      src      = SRC_MEM;
      sel_rd   = head.rd;
      sel_data = head.data;
    end
  end

  assign pop = (src == SRC_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (src != SRC_NONE) begin
      RegWrite  <= 1'b1;
      WriteReg  <= sel_rd;
      WriteData <= sel_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign issue_stall = issue_valid && (issue_rd != '0) && (cnt[issue_rd] == '1);

  // Decrement at selection time; a zero counter absorbs misuse without underflow.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      inc[r] = issue_valid && !issue_stall && (issue_rd == ADDR_W'(r));
      dec[r] = (src != SRC_NONE) && (sel_rd == ADDR_W'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (!inc[r] && dec[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) busy[r] = (cnt[r] != '0);
  end

`ifdef WB_FWD_EN
  assign fwd_hit1  = RegWrite && (WriteReg == fwd_addr1) && (fwd_addr1 != '0);
  assign fwd_hit2  = RegWrite && (WriteReg == fwd_addr2) && (fwd_addr2 != '0);
  assign fwd_data1 = fwd_hit1 ? WriteData : '0;
  assign fwd_data2 = fwd_hit2 ? WriteData : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [31:0] busy;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr1;
  logic [4:0]  fwd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W (32),
    .ADDR_W (5),
    .DEPTH  (4),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .busy        (busy),
`ifdef WB_FWD_EN
    .fwd_addr1   (fwd_addr1),
    .fwd_addr2   (fwd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2),
`endif
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData)
  );

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
`ifdef WB_FWD_EN
    fwd_addr1 = 0; fwd_addr2 = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    // Load the FIFO with 3 entries while the ALU holds the port, and mark r5 busy.
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    mem_valid = 1; mem_rd = 10; mem_data = 32'hA;
    issue_valid = 1; issue_rd = 5;
    @(negedge clk);
    issue_valid = 0; mem_rd = 11;
    @(negedge clk);
    mem_rd = 12;
    @(negedge clk);
    checks++;
    if (busy[5] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy5: got %b want 1", busy[5]); end
    reset = 1; alu_valid = 0; mem_valid = 0;
    @(negedge clk);
    reset = 0;
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    checks++;
    if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready); end
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++;
    if (WriteReg !== 5'd0 || WriteData !== 32'h0) begin
      errors++; $display("FAIL reset_wb_regs: got r%0d=%h want r0=0", WriteReg, WriteData);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_fifo_flushed: got RegWrite=%b want 0", RegWrite); end
  endtask

  task automatic test_alu();
    do_reset();
    issue_valid = 1; issue_rd = 7;
    @(negedge clk);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (busy[7] !== 1'b1) begin errors++; $display("FAIL alu_busy_set: got %b want 1", busy[7]); end
    @(negedge clk);
    alu_valid = 0;
    checks++;
    if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || WriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: got we=%b r%0d=%h want we=1 r7=deadbeef", RegWrite, WriteReg, WriteData);
    end
    checks++;
    if (busy[7] !== 1'b0) begin errors++; $display("FAIL alu_busy_clear: got %b want 0", busy[7]); end
`ifdef WB_FWD_EN
    fwd_addr1 = 7; fwd_addr2 = 6;
    #1;
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEADBEEF || fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin
      errors++; $display("FAIL fwd: got h1=%b d1=%h h2=%b d2=%h want 1 deadbeef 0 0", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
    end
`endif
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || WriteReg !== 5'd7 || WriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_hold: got we=%b r%0d=%h want we=0 r7=deadbeef", RegWrite, WriteReg, WriteData);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready: got %b want 1", mem_ready); end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'h11) begin
      errors++; $display("FAIL conflict_alu: got we=%b r%0d=%h want we=1 r3=11", RegWrite, WriteReg, WriteData);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'h22) begin
      errors++; $display("FAIL conflict_mem: got we=%b r%0d=%h want we=1 r4=22", RegWrite, WriteReg, WriteData);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL conflict_idle: got %b want 0", RegWrite); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    alu_valid = 1; alu_rd = 20;
    mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'(i);
      mem_rd = 5'(i + 1); mem_data = 32'h100 + 32'(i);
      #1;
      checks++;
      if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d_ready: got %b want 1", i, mem_ready); end
      @(negedge clk);
    end
    mem_rd = 5; mem_data = 32'h999;
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_fifth_ready: got %b want 0", mem_ready); end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_still_full: got %b want 0", mem_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (RegWrite !== 1'b1 || WriteReg !== 5'(i + 1) || WriteData !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL full_drain%0d: got we=%b r%0d=%h want we=1 r%0d=%h",
                           i, RegWrite, WriteReg, WriteData, i + 1, 32'h100 + 32'(i));
      end
      if (i == 0) begin
        checks++;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", mem_ready); end
      end
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL full_fifth_dropped: got we=%b r%0d want we=0", RegWrite, WriteReg); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_rd = 9;
      #1;
      checks++;
      if (issue_stall !== 1'b0) begin errors++; $display("FAIL sat_issue%0d_stall: got %b want 0", i, issue_stall); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_fourth_stall: got %b want 1", issue_stall); end
    @(negedge clk);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_held_at_3: got %b want 1", issue_stall); end
    issue_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    @(negedge clk);
    alu_valid = 1; issue_valid = 1; issue_rd = 9;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL sat_after_write: got %b want 0", issue_stall); end
    @(negedge clk);
    alu_valid = 0;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL sat_inc_dec_same: got %b want 0", issue_stall); end
    @(negedge clk);
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_refilled: got %b want 1", issue_stall); end
    issue_valid = 0;
  endtask

  task automatic test_reg0();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h66;
    issue_valid = 1; issue_rd = 0;
    #1;
    checks++;
    if (issue_stall !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL reg0_comb: got stall=%b ready=%b want 0 1", issue_stall, mem_ready);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL reg0_busy_ready: got busy0=%b ready=%b want 0 1", busy[0], mem_ready);
    end
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL reg0_alu_write: got %b want 0", RegWrite); end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL reg0_mem_stored: got we=%b r%0d want 0", RegWrite, WriteReg); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_conflict();
    test_full_fifo();
    test_saturation();
    test_reg0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish want finish");
    $fatal(1);
  end

endmodule
